// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255-style PPI bus master: FSM state encoding,
// PPI register addresses and the phase-timer load helper.
package ppi_pkg;

  typedef logic [2:0] ppi_state_t;

  localparam ppi_state_t ST_IDLE   = 3'd0;
  localparam ppi_state_t ST_SETUP  = 3'd1;
  localparam ppi_state_t ST_STROBE = 3'd2;
  localparam ppi_state_t ST_HOLD   = 3'd3;
  localparam ppi_state_t ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    PORTA  = 3'd0,
    PORTB  = 3'd1,
    PORTC  = 3'd2,
    CWR    = 3'd3,
    STATUS = 3'd7
  } ppi_addr_t;

  // A phase of N cycles loads N-1; a zero-length phase is stretched to one cycle.
  function automatic logic [3:0] phase_load(input int unsigned cyc);
    return (cyc == 0) ? 4'd0 : 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// Loadable 4-bit down counter that times each bus phase; zero marks the
// last cycle of the phase.
module ppi_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// Host-request to PPI bus master: runs setup / strobe / hold phases on the
// rdb/wrb/address/data pins and returns a one-cycle completion pulse.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rdb,
  output logic       wrb,
  output logic [2:0] address,
  inout  wire  [7:0] data
);

  localparam logic [3:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = phase_load(HOLD_CYC);

  ppi_state_t state, state_nxt;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic       handshake;
  logic       phase_end;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       drive_en;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign handshake = req_valid && req_ready;

  ppi_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (phase_end)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = SETUP_LD;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          state_nxt = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_nxt = ST_STROBE;
          tmr_load  = 1'b1;
          tmr_val   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (phase_end) begin
          state_nxt = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (phase_end) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      address   <= 3'd0;
      rsp_rdata <= 8'h00;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        wr_q    <= req_write;
        wdata_q <= req_wdata;
        address <= req_addr;
      end
      // Read data is captured on the edge that ends the strobe phase.
      if (state == ST_STROBE && phase_end) begin
        rsp_rdata <= wr_q ? 8'h00 : data;
      end
    end
  end

  // Strobes and bus drive decode straight from state, so an asynchronous
  // reset releases them in the same instant.
  assign rdb       = !(state == ST_STROBE && !wr_q);
  assign wrb       = !(state == ST_STROBE && wr_q);
  assign rsp_valid = (state == ST_DONE);
  assign drive_en  = wr_q && (state == ST_SETUP || state == ST_STROBE || state == ST_HOLD);
  assign data      = drive_en ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench for ppi_bus_master: two instances (default timing and a
// stretched/zero-hold timing) checked cycle by cycle against a phase model.
module tb_ppi_bus_master;

  localparam int D0_SETUP = 2, D0_STROBE = 2, D0_HOLD = 2;
  localparam int D1_SETUP = 1, D1_STROBE = 15, D1_HOLD = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_write [2];
  logic [2:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       rdb       [2];
  logic       wrb       [2];
  logic [2:0] address   [2];
  logic       dev_en    [2];
  logic [7:0] dev_val   [2];
  wire  [7:0] data0, data1;

  // Simulated PPI device: drives the bus whenever the host is not writing.
  assign data0 = dev_en[0] ? dev_val[0] : 8'hzz;
  assign data1 = dev_en[1] ? dev_val[1] : 8'hzz;

  int n_checks = 0;
  int n_pass   = 0;

  ppi_bus_master #(.SETUP_CYC(D0_SETUP), .STROBE_CYC(D0_STROBE), .HOLD_CYC(D0_HOLD)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rdb(rdb[0]), .wrb(wrb[0]), .address(address[0]), .data(data0)
  );

  ppi_bus_master #(.SETUP_CYC(D1_SETUP), .STROBE_CYC(D1_STROBE), .HOLD_CYC(D1_HOLD)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rdb(rdb[1]), .wrb(wrb[1]), .address(address[1]), .data(data1)
  );

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic [7:0] bus_val(input int d);
    return (d == 0) ? data0 : data1;
  endfunction

  function automatic int setup_of(input int d);
    return eff(d == 0 ? D0_SETUP : D1_SETUP);
  endfunction

  function automatic int strobe_of(input int d);
    return eff(d == 0 ? D0_STROBE : D1_STROBE);
  endfunction

  function automatic int hold_of(input int d);
    return eff(d == 0 ? D0_HOLD : D1_HOLD);
  endfunction

  // One full transaction checked every cycle against the phase model:
  // cycle k after the handshake is SETUP for k<=s, STROBE for s<k<=s+t,
  // HOLD up to s+t+h, and the response pulse at s+t+h+1.
  task automatic run_txn(input int d, input logic wr, input logic [2:0] a, input logic [7:0] wd,
                         input logic [7:0] rd_val, input bit vary, input bit scramble,
                         input string name);
    int s, t, h, occ, waited;
    logic in_strobe;
    logic [7:0] exp_rd;
    s = setup_of(d); t = strobe_of(d); h = hold_of(d);
    occ = s + t + h + 1;
    exp_rd = rd_val;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
    dev_en[d] = !wr; dev_val[d] = rd_val;
    waited = 0;
    while (req_ready[d] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (req_ready[d] !== 1'b1) $display("FAIL %s ready_timeout: req_ready=%b expected 1", name, req_ready[d]);
    else n_pass++;
    @(posedge clk);
    for (int k = 1; k <= occ; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid[d] = 1'b0;
        if (scramble) begin
          req_addr[d] = 3'd2; req_wdata[d] = 8'h00; req_write[d] = !wr;
        end
      end
      in_strobe = (k > s) && (k <= s + t);
      n_checks++;
      if (rdb[d] !== !(in_strobe && !wr)) $display("FAIL %s rdb cycle %0d: got %b expected %b", name, k, rdb[d], !(in_strobe && !wr));
      else n_pass++;
      n_checks++;
      if (wrb[d] !== !(in_strobe && wr)) $display("FAIL %s wrb cycle %0d: got %b expected %b", name, k, wrb[d], !(in_strobe && wr));
      else n_pass++;
      n_checks++;
      if (rsp_valid[d] !== (k == occ)) $display("FAIL %s rsp_valid cycle %0d: got %b expected %b", name, k, rsp_valid[d], (k == occ));
      else n_pass++;
      n_checks++;
      if (req_ready[d] !== 1'b0) $display("FAIL %s req_ready busy cycle %0d: got %b expected 0", name, k, req_ready[d]);
      else n_pass++;
      n_checks++;
      if (address[d] !== a) $display("FAIL %s address cycle %0d: got %0d expected %0d", name, k, address[d], a);
      else n_pass++;
      if (wr && k <= s + t + h) begin
        n_checks++;
        if (bus_val(d) !== wd) $display("FAIL %s write data cycle %0d: got %h expected %h", name, k, bus_val(d), wd);
        else n_pass++;
      end else if (!wr) begin
        n_checks++;
        if (bus_val(d) !== dev_val[d]) $display("FAIL %s bus contention cycle %0d: got %h expected %h", name, k, bus_val(d), dev_val[d]);
        else n_pass++;
      end
      if (k == occ) begin
        n_checks++;
        if (rsp_rdata[d] !== (wr ? 8'h00 : exp_rd)) $display("FAIL %s rsp_rdata: got %h expected %h", name, rsp_rdata[d], (wr ? 8'h00 : exp_rd));
        else n_pass++;
      end
      if (vary && !wr) dev_val[d] = 8'($urandom);
      if (!wr && k == s + t) exp_rd = dev_val[d];
    end
    @(negedge clk);
    dev_en[d] = 1'b1;
    dev_val[d] = 8'($urandom);
    #1;
    n_checks++;
    if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) $display("FAIL %s idle after: ready=%b rsp_valid=%b expected 1/0", name, req_ready[d], rsp_valid[d]);
    else n_pass++;
    n_checks++;
    if (address[d] !== a) $display("FAIL %s address retained: got %0d expected %0d", name, address[d], a);
    else n_pass++;
    n_checks++;
    if (bus_val(d) !== dev_val[d]) $display("FAIL %s idle bus released: got %h expected %h", name, bus_val(d), dev_val[d]);
    else n_pass++;
  endtask

  task automatic check_reset_state(input string name);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rdb[d] !== 1'b1 || wrb[d] !== 1'b1) $display("FAIL %s strobes dut%0d: rdb=%b wrb=%b expected 1/1", name, d, rdb[d], wrb[d]);
      else n_pass++;
      n_checks++;
      if (address[d] !== 3'd0 || req_ready[d] !== 1'b0) $display("FAIL %s addr/ready dut%0d: address=%0d ready=%b expected 0/0", name, d, address[d], req_ready[d]);
      else n_pass++;
      n_checks++;
      if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 8'h00) $display("FAIL %s rsp dut%0d: valid=%b rdata=%h expected 0/00", name, d, rsp_valid[d], rsp_rdata[d]);
      else n_pass++;
      n_checks++;
      if (bus_val(d) !== dev_val[d]) $display("FAIL %s bus dut%0d: got %h expected %h", name, d, bus_val(d), dev_val[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1) $display("FAIL reset release dut%0d: req_ready=%b expected 1", d, req_ready[d]);
      else n_pass++;
    end
  endtask

  task automatic test_write_default();
    run_txn(0, 1'b1, 3'd3, 8'hC6, 8'h00, 1'b0, 1'b0, "write_c6");
  endtask

  task automatic test_read_default();
    run_txn(0, 1'b0, 3'd0, 8'h00, 8'hA5, 1'b0, 1'b0, "read_a5");
  endtask

  task automatic test_hold_after_handshake();
    run_txn(0, 1'b1, 3'd0, 8'hAA, 8'h00, 1'b0, 1'b1, "req_change");
  endtask

  task automatic test_back_to_back();
    int gap, waited;
    gap = setup_of(0) + strobe_of(0) + hold_of(0) + 2;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 3'd7; req_wdata[0] = 8'hFF;
    dev_en[0] = 1'b0;
    waited = 0;
    while (req_ready[0] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    for (int k = 1; k <= gap; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_write[0] = 1'b0; req_addr[0] = 3'd1; req_wdata[0] = 8'h00;
      end
      if (k == gap - 1) begin
        dev_en[0] = 1'b1; dev_val[0] = 8'h35;
      end
      n_checks++;
      if (req_ready[0] !== (k == gap)) $display("FAIL b2b spacing cycle %0d: req_ready=%b expected %b", k, req_ready[0], (k == gap));
      else n_pass++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    waited = 1;
    while (rsp_valid[0] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited !== gap - 1) $display("FAIL b2b read latency: got %0d cycles expected %0d", waited, gap - 1);
    else n_pass++;
    n_checks++;
    if (rsp_rdata[0] !== 8'h35) $display("FAIL b2b read data: got %h expected 35", rsp_rdata[0]);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_params();
    run_txn(1, 1'b1, 3'd2, 8'h5A, 8'h00, 1'b0, 1'b0, "long_write");
    run_txn(1, 1'b0, 3'd3, 8'h00, 8'h81, 1'b1, 1'b1, "long_read");
  endtask

  task automatic test_random();
    logic [2:0] addrs [5];
    addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    for (int i = 0; i < 16; i++) begin
      run_txn(0, 1'($urandom), addrs[$urandom_range(0, 4)], 8'($urandom), 8'($urandom),
              1'b1, 1'($urandom), "random_d0");
    end
    for (int i = 0; i < 3; i++) begin
      run_txn(1, 1'($urandom), addrs[$urandom_range(0, 4)], 8'($urandom), 8'($urandom),
              1'b1, 1'($urandom), "random_d1");
    end
  endtask

  task automatic test_reset_mid_write();
    int waited;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 3'd3; req_wdata[0] = 8'hC6;
    dev_en[0] = 1'b0;
    waited = 0;
    while (req_ready[0] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    for (int k = 1; k <= setup_of(0) + 1; k++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
    end
    n_checks++;
    if (wrb[0] !== 1'b0) $display("FAIL midreset precondition: wrb=%b expected 0", wrb[0]);
    else n_pass++;
    reset = 1'b1;
    dev_en[0] = 1'b1; dev_val[0] = 8'h3C;
    #1;
    check_reset_state("midreset");
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) $display("FAIL midreset held: rsp_valid=%b ready=%b expected 0/0", rsp_valid[0], req_ready[0]);
      else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready[0] !== 1'b1) $display("FAIL midreset release: req_ready=%b expected 1", req_ready[0]);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[0] !== 1'b0 || wrb[0] !== 1'b1) $display("FAIL midreset aftermath cycle %0d: rsp_valid=%b wrb=%b expected 0/1", k, rsp_valid[0], wrb[0]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 3'd0; req_wdata[d] = 8'h00;
      dev_en[d] = 1'b1; dev_val[d] = 8'($urandom);
    end
    test_reset();
    test_write_default();
    test_read_default();
    test_hold_after_handshake();
    test_back_to_back();
    test_params();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
